// File: rtl/t06_button_conditioner_if.sv
// Button bundle between the raw board inputs and the conditioned outputs.
//   btn_raw   : raw, bouncing, active-high button inputs
//   btn_level : debounced level per channel
//   btn_pulse : one-cycle press strobe per channel
//   btn_any   : OR of btn_pulse
// master drives btn_raw and observes the results; slave is the conditioner.
interface t06_button_conditioner_if #(
  parameter int unsigned NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic               btn_any;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse,
    input  btn_any
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse,
    output btn_any
  );
endinterface

// File: rtl/t06_button_conditioner.sv
// Push-button conditioner: per-channel two-flop synchronizer, counter-based
// debouncer, registered press strobe and an OR of all strobes.
// Optional auto-repeat of the press strobe while a button stays down is built
// in when the macro BTN_AUTOREPEAT_EN is defined.
//   system_clk : single clock, rising edge
//   nrst       : synchronous active-low reset
//   btn_bus    : slave side of t06_button_conditioner_if
//                (btn_raw in; btn_level, btn_pulse, btn_any out, all registered)
module t06_button_conditioner #(
  parameter int unsigned NUM_BTN       = 5,
  parameter int unsigned DB_CYCLES     = 50000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input logic                     system_clk,
  input logic                     nrst,
  t06_button_conditioner_if.slave btn_bus
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] pulse_q;
  logic [NUM_BTN-1:0] pulse_d;
  logic [NUM_BTN-1:0] rise_d;
  logic               any_q;
  logic [CNT_W-1:0]   db_cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   db_cnt_d [NUM_BTN];

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      db_cnt_d[i] = '0;
      if (sync_q2[i] != level_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          level_d[i] = ~level_q[i];
          rise_d[i]  = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0]   rpt_cnt_q [NUM_BTN];
  logic [RPT_W-1:0]   rpt_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] rpt_armed_q;
  logic [NUM_BTN-1:0] rpt_armed_d;
  logic [NUM_BTN-1:0] rpt_fire;

  // Auto-repeat: first re-issue after REPEAT_DELAY, then every REPEAT_PERIOD.
  // The counter restarts on each re-issue, so armed marks the periodic phase.
  always_comb begin
    rpt_armed_d = rpt_armed_q;
    rpt_fire    = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (rise_d[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_armed_d[i] = 1'b0;
      end else if (level_q[i] && level_d[i]) begin
        if (!rpt_armed_q[i] && (rpt_cnt_q[i] == RPT_W'(REPEAT_DELAY - 1))) begin
          rpt_fire[i]    = 1'b1;
          rpt_cnt_d[i]   = '0;
          rpt_armed_d[i] = 1'b1;
        end else if (rpt_armed_q[i] && (rpt_cnt_q[i] == RPT_W'(REPEAT_PERIOD - 1))) begin
          rpt_fire[i]  = 1'b1;
          rpt_cnt_d[i] = '0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
        end
      end else begin
        // Released (or releasing this cycle): no repeat on the falling edge.
        rpt_cnt_d[i]   = '0;
        rpt_armed_d[i] = 1'b0;
      end
    end
  end

  assign pulse_d = rise_d | rpt_fire;

  // Repeat state registers.
  always_ff @(posedge system_clk) begin
    if (!nrst) begin
      rpt_armed_q <= '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      rpt_armed_q <= rpt_armed_d;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end
`else
  assign pulse_d = rise_d;

  // Repeat timing has no effect without auto-repeat built in.
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_rpt_unused
  end
`endif

  // Synchronizer, debounce state and registered outputs.
  always_ff @(posedge system_clk) begin
    if (!nrst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync_q1 <= btn_bus.btn_raw;
      sync_q2 <= sync_q1;
      level_q <= level_d;
      pulse_q <= pulse_d;
      any_q   <= |pulse_d;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign btn_bus.btn_level = level_q;
  assign btn_bus.btn_pulse = pulse_q;
  assign btn_bus.btn_any   = any_q;

endmodule
